// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO on a valid/ready stream, DEPTH x WIDTH entries.
// Decouples a producer from a downstream consumer so that a stalled out_ready
// only back-pressures the producer once the buffer is full. Ordering is
// preserved and the current occupancy is reported.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears pointers, count, storage
//   in_data    upstream payload
//   in_valid   upstream beat present
//   in_ready   FIFO can accept a beat (registered state only, no path from out_ready)
//   out_data   payload at the head of the FIFO
//   out_valid  head entry valid
//   out_ready  downstream accepts the head entry
//   count      occupied entries, 0..DEPTH
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push;
  logic             pop;

  // in_ready is forced low during reset so nothing is accepted while held.
  always_comb begin
    in_ready  = !rst && (count != FULL_COUNT);
    out_valid = (count != '0);
    out_data  = mem[rp];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      mem   <= '{default: '0};
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous FIFO on a 32-bit valid/ready stream. It sits directly upstream of a module that drives a `bar` interface bundle (`data[31:0]`, `valid`, `ready`). It decouples a producer from that consumer so a stalled `ready` does not back-pressure the producer until the buffer is full. Ordering is preserved, no beat is ever dropped or duplicated, and the current fill level is reported.

## Interface
- `WIDTH`, 32, payload width in bits; matches `bar.data`.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  upstream payload.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  FIFO can accept a beat this cycle.
- `out_data`  out  WIDTH  payload at head of FIFO; drives `bar.data`.
- `out_valid`  out  1  head entry valid; drives `bar.valid`.
- `out_ready`  in  1  downstream accepts; driven from `bar.ready`.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation
- **Storage and state**
  - Storage: `DEPTH` × `WIDTH` register array.
  - Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits.
  - Occupancy register `count`.
- **Transfers**
  - push = `in_valid & in_ready`; writes `in_data` to `mem[wp]` and sets `wp <= wp+1`.
  - pop = `out_valid & out_ready`; sets `rp <= rp+1`.
  - Pointers wrap modulo `DEPTH` by natural overflow; there is no explicit compare.
- **count update**
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: unchanged.
- **Output decode**
  - `in_ready` = `!rst && count != DEPTH`. It depends only on registered state, never on `out_ready`, so there is no combinational ready path.
  - `out_valid` = `count != 0`.
  - `out_data` = `mem[rp]`. It must hold stable while `out_valid & !out_ready`.
- **Occupancy states**
  - EMPTY (`count==0`): pop impossible. A push moves the FIFO to PARTIAL, or to FULL when `DEPTH==1` (excluded by parameter rule).
  - PARTIAL: push and pop both legal, including together.
  - FULL (`count==DEPTH`): push impossible. A pop returns the FIFO to PARTIAL.
- **Protocol assumptions**
  - Upstream may deassert `in_valid` or change `in_data` while `in_ready` is low; the FIFO ignores both.
  - Downstream may hold `out_ready` high while `out_valid` is low; no pop occurs.
- **Illegal parameters**: `DEPTH` not a power of two is a compile-time error via an elaboration check.

## Timing
- **Reset**
  - Assertion immediately forces `wp=0`, `rp=0`, `count=0`, all `mem` entries 0. Hence `out_valid=0`, `out_data=0`, `in_ready=0`.
  - After deassertion, `in_ready` rises combinationally (`count=0`). The first push is possible on the first rising edge with `rst` low.
  - Reset mid-operation discards all contents with no partial pop or push. Beats in flight are lost by design.
- **Latency**
  - Input to output is 1 cycle: a beat pushed at edge N makes `out_valid=1` with that data after edge N.
  - There is no bypass of the register array.
- **Throughput**
  - 1 beat/cycle sustained when `out_ready` is held high.
  - When FULL with `out_ready=1`, the pop at edge N makes `in_ready=1` after N. The producer loses one cycle, an accepted bubble.
- **Simultaneous events**
  - Push and pop in the same cycle at `count=1`: the old head leaves, the new beat becomes head after the edge, and `count` stays 1.
  - Push and pop together at `count=DEPTH` cannot occur because `in_ready=0`.
- **`count`** is registered and updates on the same edge as the pointers.

## Test plan
- **Reset state**: assert `rst` with `in_valid=1`, `in_data=42` → `in_ready=0`, `out_valid=0`, `out_data=0`, `count=0`, and nothing stored after release.
- **Single beat**
  - Stimulus: push 42 with `out_ready=0`.
  - Required: next cycle `out_valid=1`, `out_data=42`, `count=1`. It holds for 5 cycles.
  - Then `out_ready=1` for one cycle → `count=0`, `out_valid=0`.
- **Fill and overflow guard**
  - Stimulus: `DEPTH=4`, `out_ready=0`, push 1,2,3,4, then offer 5 for 3 cycles.
  - Required: `count=4`, `in_ready=0`, and 5 is never accepted.
  - Drain → outputs 1,2,3,4 in order.
- **Streaming**: `out_ready=1`, push 0..99 back-to-back → 100 outputs, in order, one per cycle after the first, and `count` ≤ 1 throughout.
- **Wrap and simultaneous push/pop**
  - Stimulus: random `in_valid`/`out_ready` at 50% for 1000 cycles against a scoreboard model.
  - Required: no loss, no duplication, and `count` always equals model occupancy across pointer wrap.
- **Mid-operation reset**: with `count=3`, pulse `rst` between edges → `count=0` and `out_valid=0` immediately. A subsequent push of 7 appears as the first output.
